// File: rtl/ti_polyphase_decim.sv
// ti_polyphase_decim
// Polyphase decimator front end. Signed samples shift through an M-deep
// tapped delay line. Every M accepted samples, the post-shift taps are
// captured in parallel into an M-lane output register. A one-cycle valid
// strobe marks each capture. Decimation comes from an internal phase counter,
// so the whole block runs on a single clock.

module ti_polyphase_decim #(
    parameter int BW       = 6,
    parameter int M        = 4,
    parameter int LANE_REV = 0,
    parameter int CW       = $clog2(M)
) (
    input  logic                 i_clk,
    input  logic                 i_res,
    input  logic                 i_enable,
    input  logic                 i_sync,
    input  logic signed [BW-1:0] i_in,
    output logic [M*BW-1:0]      o_out,
    output logic                 o_out_valid,
    output logic [CW-1:0]        o_phase
);

    localparam logic [CW-1:0] LAST_PHASE = CW'(M - 1);
    localparam logic [CW-1:0] ONE_PHASE  = CW'(1);

    logic [BW-1:0]   r_z [1:M];
    logic [CW-1:0]   r_cnt;
    logic [M*BW-1:0] r_out;
    logic            r_out_valid;

    logic            w_strobe;
    logic [BW-1:0]   w_p [1:M];
    logic [M*BW-1:0] w_lanes;

    // Frame-complete strobe: last phase accepted, not pre-empted by a realignment
    always_comb begin
        w_strobe = i_enable & ~i_sync & (r_cnt == LAST_PHASE);
    end

    // Post-shift view of the delay line; the current input is the newest tap
    always_comb begin
        w_p[1] = i_in;
        for (int k = 2; k <= M; k++) begin
            w_p[k] = r_z[k-1];
        end
    end

    // Map post-shift taps onto output lanes (newest-first or oldest-first)
    always_comb begin
        w_lanes = '0;
        for (int k = 0; k < M; k++) begin
            if (LANE_REV == 0) begin
                w_lanes[k*BW +: BW] = w_p[k+1];
            end else begin
                w_lanes[k*BW +: BW] = w_p[M-k];
            end
        end
    end

    // Tapped delay line: shifts only on accepted samples, SYNC does not block it
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            for (int k = 1; k <= M; k++) begin
                r_z[k] <= '0;
            end
        end else if (i_enable) begin
            r_z[1] <= i_in;
            for (int k = 2; k <= M; k++) begin
                r_z[k] <= r_z[k-1];
            end
        end
    end

    // Phase counter: a SYNC edge makes its own accepted sample phase 0 of a new frame
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_cnt <= '0;
        end else if (i_sync) begin
            r_cnt <= i_enable ? ONE_PHASE : '0;
        end else if (i_enable) begin
            r_cnt <= w_strobe ? '0 : (r_cnt + ONE_PHASE);
        end
    end

    // Output frame register and its one-cycle valid strobe
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_strobe;
            if (w_strobe) begin
                r_out <= w_lanes;
            end
        end
    end

    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_phase     = r_cnt;

endmodule

// File: tb/tb_ti_polyphase_decim.sv
// Testbench for ti_polyphase_decim. Four builds share one stimulus stream:
// M=4 newest-first, M=4 oldest-first, M=2 and M=16. A frame-based reference
// model collects accepted samples per frame and emits lanes once a frame fills.

module tb_ti_polyphase_decim;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              res;
    logic              en;
    logic              sync;
    logic signed [5:0] din;

    logic [23:0] out0, out1;
    logic [11:0] out2;
    logic [95:0] out3;
    logic        v0, v1, v2, v3;
    logic [1:0]  ph0, ph1;
    logic [0:0]  ph2;
    logic [3:0]  ph3;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // reference model state: per build, the samples of the current frame
    int          mm  [4] = '{4, 4, 2, 16};
    int          rev [4] = '{0, 1, 0, 0};
    int          fr  [4][16];
    int          fn  [4];
    logic [95:0] e_out [4];
    logic        e_v   [4];
    logic [3:0]  e_ph  [4];

    ti_polyphase_decim #(.BW(6), .M(4), .LANE_REV(0)) u_m4 (
        .i_clk(clk), .i_res(res), .i_enable(en), .i_sync(sync), .i_in(din),
        .o_out(out0), .o_out_valid(v0), .o_phase(ph0));
    ti_polyphase_decim #(.BW(6), .M(4), .LANE_REV(1)) u_m4r (
        .i_clk(clk), .i_res(res), .i_enable(en), .i_sync(sync), .i_in(din),
        .o_out(out1), .o_out_valid(v1), .o_phase(ph1));
    ti_polyphase_decim #(.BW(6), .M(2), .LANE_REV(0)) u_m2 (
        .i_clk(clk), .i_res(res), .i_enable(en), .i_sync(sync), .i_in(din),
        .o_out(out2), .o_out_valid(v2), .o_phase(ph2));
    ti_polyphase_decim #(.BW(6), .M(16), .LANE_REV(0)) u_m16 (
        .i_clk(clk), .i_res(res), .i_enable(en), .i_sync(sync), .i_in(din),
        .o_out(out3), .o_out_valid(v3), .o_phase(ph3));

    // Frame model: RES clears, SYNC starts a new frame, a full frame yields lanes
    task automatic model_update();
        for (int i = 0; i < 4; i++) begin
            e_v[i] = 1'b0;
            if (res) begin
                fn[i]    = 0;
                e_out[i] = '0;
            end else if (sync) begin
                if (en) begin
                    fr[i][0] = int'(din);
                    fn[i]    = 1;
                end else begin
                    fn[i] = 0;
                end
            end else if (en) begin
                fr[i][fn[i]] = int'(din);
                fn[i]++;
                if (fn[i] == mm[i]) begin
                    e_v[i]   = 1'b1;
                    e_out[i] = '0;
                    for (int k = 0; k < mm[i]; k++) begin
                        e_out[i][k*6 +: 6] = 6'((rev[i] == 0) ? fr[i][mm[i]-1-k] : fr[i][k]);
                    end
                    fn[i] = 0;
                end
            end
            e_ph[i] = 4'(fn[i]);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic s, input logic signed [5:0] d);
        res  = r;
        en   = e;
        sync = s;
        din  = d;
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 6'sd17);
        n_chk++;
        if (v0 !== 1'b0 || ph0 !== 2'd0 || out0 !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_m4: got v=%b ph=%0d out=%h, want 0/0/0", v0, ph0, out0);
        end
        n_chk++;
        if (v1 !== 1'b0 || ph1 !== 2'd0 || out1 !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_m4r: got v=%b ph=%0d out=%h, want 0/0/0", v1, ph1, out1);
        end
        n_chk++;
        if (v2 !== 1'b0 || ph2 !== 1'd0 || out2 !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_m2: got v=%b ph=%0d out=%h, want 0/0/0", v2, ph2, out2);
        end
        n_chk++;
        if (v3 !== 1'b0 || ph3 !== 4'd0 || out3 !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_m16: got v=%b ph=%0d out=%h, want 0/0/0", v3, ph3, out3);
        end
    endtask

    task automatic test_ramp();
        logic [23:0] f1;
        logic [23:0] f2;
        logic        want_v;
        logic [1:0]  want_ph;
        f1 = {6'd1, 6'd2, 6'd3, 6'd4};
        f2 = {6'd5, 6'd6, 6'd7, 6'd8};
        step(1'b1, 1'b0, 1'b0, 6'sd0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 6'(i));
            want_v  = (i % 4 == 0);
            want_ph = 2'(i % 4);
            n_chk++;
            if (v0 !== want_v || ph0 !== want_ph) begin
                n_fail++;
                $display("FAIL ramp_strobe i=%0d: got v=%b ph=%0d, want v=%b ph=%0d", i, v0, ph0, want_v, want_ph);
            end
            if (i == 4 || i == 8) begin
                n_chk++;
                if (out0 !== ((i == 4) ? f1 : f2)) begin
                    n_fail++;
                    $display("FAIL ramp_lanes i=%0d: got %h, want %h", i, out0, (i == 4) ? f1 : f2);
                end
            end
            n_chk++;
            if (v1 !== e_v[1] || ph1 !== e_ph[1][1:0] || out1 !== e_out[1][23:0]) begin
                n_fail++;
                $display("FAIL ramp_rev i=%0d: got v=%b ph=%0d out=%h, want v=%b ph=%0d out=%h",
                         i, v1, ph1, out1, e_v[1], e_ph[1][1:0], e_out[1][23:0]);
            end
        end
    endtask

    task automatic test_gaps();
        int          acc;
        logic        want_v;
        logic [23:0] f1;
        f1  = {6'd1, 6'd2, 6'd3, 6'd4};
        acc = 0;
        step(1'b1, 1'b0, 1'b0, 6'sd0);
        for (int c = 0; c < 16; c++) begin
            if (c % 2 == 0) begin
                acc++;
                step(1'b0, 1'b1, 1'b0, 6'(acc));
                want_v = (acc % 4 == 0);
            end else begin
                step(1'b0, 1'b0, 1'b0, 6'($urandom));
                want_v = 1'b0;
            end
            n_chk++;
            if (v0 !== want_v || v0 !== e_v[0] || ph0 !== e_ph[0][1:0] || out0 !== e_out[0][23:0]) begin
                n_fail++;
                $display("FAIL gaps c=%0d: got v=%b ph=%0d out=%h, want v=%b ph=%0d out=%h",
                         c, v0, ph0, out0, e_v[0], e_ph[0][1:0], e_out[0][23:0]);
            end
            if (c == 6) begin
                n_chk++;
                if (out0 !== f1) begin
                    n_fail++;
                    $display("FAIL gaps_lanes: got %h, want %h", out0, f1);
                end
            end
        end
    endtask

    task automatic test_signed();
        logic [23:0] want_n;
        logic [23:0] want_r;
        want_n = {6'b100000, 6'b011111, 6'b111111, 6'b000000};
        want_r = {6'b000000, 6'b111111, 6'b011111, 6'b100000};
        step(1'b1, 1'b0, 1'b0, 6'sd0);
        step(1'b0, 1'b1, 1'b0, -6'sd32);
        step(1'b0, 1'b1, 1'b0, 6'sd31);
        step(1'b0, 1'b1, 1'b0, -6'sd1);
        step(1'b0, 1'b1, 1'b0, 6'sd0);
        n_chk++;
        if (v0 !== 1'b1 || out0 !== want_n) begin
            n_fail++;
            $display("FAIL signed_newest: got v=%b out=%h, want v=1 out=%h", v0, out0, want_n);
        end
        n_chk++;
        if (v1 !== 1'b1 || out1 !== want_r) begin
            n_fail++;
            $display("FAIL signed_oldest: got v=%b out=%h, want v=1 out=%h", v1, out1, want_r);
        end
    endtask

    task automatic test_sync();
        logic [23:0] want;
        want = {6'd3, 6'd20, 6'd21, 6'd22};
        step(1'b1, 1'b0, 1'b0, 6'sd0);
        step(1'b0, 1'b1, 1'b0, 6'sd10);
        step(1'b0, 1'b1, 1'b0, 6'sd11);
        step(1'b0, 1'b1, 1'b1, 6'sd3);
        n_chk++;
        if (v0 !== 1'b0 || ph0 !== 2'd1) begin
            n_fail++;
            $display("FAIL sync_edge: got v=%b ph=%0d, want v=0 ph=1", v0, ph0);
        end
        step(1'b0, 1'b1, 1'b0, 6'sd20);
        step(1'b0, 1'b1, 1'b0, 6'sd21);
        n_chk++;
        if (v0 !== 1'b0 || ph0 !== 2'd3) begin
            n_fail++;
            $display("FAIL sync_mid: got v=%b ph=%0d, want v=0 ph=3", v0, ph0);
        end
        step(1'b0, 1'b1, 1'b0, 6'sd22);
        n_chk++;
        if (v0 !== 1'b1 || out0 !== want || ph0 !== 2'd0) begin
            n_fail++;
            $display("FAIL sync_frame: got v=%b out=%h ph=%0d, want v=1 out=%h ph=0", v0, out0, ph0, want);
        end
        // SYNC coinciding with the last phase: no strobe, sample becomes phase 0
        step(1'b0, 1'b1, 1'b0, 6'sd1);
        step(1'b0, 1'b1, 1'b0, 6'sd2);
        step(1'b0, 1'b1, 1'b0, 6'sd3);
        step(1'b0, 1'b1, 1'b1, 6'sd4);
        n_chk++;
        if (v0 !== 1'b0 || ph0 !== 2'd1 || out0 !== want) begin
            n_fail++;
            $display("FAIL sync_last: got v=%b ph=%0d out=%h, want v=0 ph=1 out=%h", v0, ph0, out0, want);
        end
    endtask

    task automatic test_reset_midframe();
        logic [23:0] want;
        logic        want_v;
        want = {6'd9, 6'd10, 6'd11, 6'd12};
        step(1'b1, 1'b0, 1'b0, 6'sd0);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 1'b1, 1'b0, 6'(i));
        end
        step(1'b1, 1'b1, 1'b0, 6'sd8);
        n_chk++;
        if (v0 !== 1'b0 || ph0 !== 2'd0 || out0 !== 24'd0) begin
            n_fail++;
            $display("FAIL res_mid: got v=%b ph=%0d out=%h, want 0/0/0", v0, ph0, out0);
        end
        for (int i = 9; i <= 12; i++) begin
            step(1'b0, 1'b1, 1'b0, 6'(i));
            want_v = (i == 12);
            n_chk++;
            if (v0 !== want_v || (want_v && out0 !== want)) begin
                n_fail++;
                $display("FAIL res_refill i=%0d: got v=%b out=%h, want v=%b out=%h", i, v0, out0, want_v, want);
            end
        end
    endtask

    task automatic test_random();
        logic r, e, s;
        step(1'b1, 1'b0, 1'b0, 6'sd0);
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 11) == 0);
            e = ($urandom_range(0, 9) < 7);
            step(r, e, s, 6'($urandom));
            n_chk++;
            if (v0 !== e_v[0] || ph0 !== e_ph[0][1:0] || out0 !== e_out[0][23:0] ||
                v1 !== e_v[1] || ph1 !== e_ph[1][1:0] || out1 !== e_out[1][23:0]) begin
                n_fail++;
                $display("FAIL rand_m4 c=%0d: got %b/%0d/%h %b/%0d/%h, want %b/%0d/%h %b/%0d/%h", c,
                         v0, ph0, out0, v1, ph1, out1, e_v[0], e_ph[0][1:0], e_out[0][23:0],
                         e_v[1], e_ph[1][1:0], e_out[1][23:0]);
            end
            n_chk++;
            if (v2 !== e_v[2] || ph2 !== e_ph[2][0:0] || out2 !== e_out[2][11:0] ||
                v3 !== e_v[3] || ph3 !== e_ph[3] || out3 !== e_out[3]) begin
                n_fail++;
                $display("FAIL rand_m2m16 c=%0d: got %b/%0d/%h %b/%0d/%h, want %b/%0d/%h %b/%0d/%h", c,
                         v2, ph2, out2, v3, ph3, out3, e_v[2], e_ph[2][0:0], e_out[2][11:0],
                         e_v[3], e_ph[3], e_out[3]);
            end
        end
    endtask

    task automatic test_period();
        int last2;
        int last3;
        int n2;
        int n3;
        last2 = -1;
        last3 = -1;
        n2    = 0;
        n3    = 0;
        step(1'b1, 1'b0, 1'b0, 6'sd0);
        for (int c = 0; c < 48; c++) begin
            step(1'b0, 1'b1, 1'b0, 6'($urandom));
            if (v2 === 1'b1) begin
                n2++;
                if (last2 >= 0) begin
                    n_chk++;
                    if (cyc - last2 != 2) begin
                        n_fail++;
                        $display("FAIL period_m2: got %0d cycles, want 2", cyc - last2);
                    end
                end
                last2 = cyc;
            end
            if (v3 === 1'b1) begin
                n3++;
                if (last3 >= 0) begin
                    n_chk++;
                    if (cyc - last3 != 16) begin
                        n_fail++;
                        $display("FAIL period_m16: got %0d cycles, want 16", cyc - last3);
                    end
                end
                last3 = cyc;
            end
            n_chk++;
            if (v2 !== e_v[2] || out2 !== e_out[2][11:0] || v3 !== e_v[3] || out3 !== e_out[3]) begin
                n_fail++;
                $display("FAIL period_lanes c=%0d: got %b/%h %b/%h, want %b/%h %b/%h", c,
                         v2, out2, v3, out3, e_v[2], e_out[2][11:0], e_v[3], e_out[3]);
            end
        end
        n_chk++;
        if (n2 != 24 || n3 != 3) begin
            n_fail++;
            $display("FAIL period_count: got %0d/%0d strobes, want 24/3", n2, n3);
        end
    endtask

    initial begin
        res  = 1'b1;
        en   = 1'b0;
        sync = 1'b0;
        din  = 6'sd0;
        test_reset();
        test_ramp();
        test_gaps();
        test_signed();
        test_sync();
        test_reset_midframe();
        test_random();
        test_period();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
